// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: cell codes, board size, controller states
// and cell-slice helpers used by the controller and the victory detector.
package tictactoe_pkg;

  localparam int N_CELLS = 9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [1:0] {IDLE, TURN, CHECK, OVER} ctrl_state_t;

  // Out-of-range indices read back as 2'b11 so they never look empty.
  function automatic logic [1:0] cell_of(input logic [2*N_CELLS-1:0] board,
                                         input logic [3:0] idx);
    logic [1:0] c;
    c = 2'b11;
    for (int i = 0; i < N_CELLS; i++)
      if (idx == 4'(i)) c = board[2*i +: 2];
    return c;
  endfunction

  function automatic logic [1:0] player_code(input logic p);
    return p ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/empty_cell_finder.sv
// Combinational priority encoder: lowest-indexed empty cell on the board.
module empty_cell_finder
  import tictactoe_pkg::*;
(
  input  logic [2*N_CELLS-1:0] board,
  output logic [3:0]           idx,
  output logic                 found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_CELLS - 1; i >= 0; i--)
      if (board[2*i +: 2] == CELL_EMPTY) begin
        idx   = 4'(i);
        found = 1'b1;
      end
  end

endmodule

// File: rtl/board_controller.sv
// Tic-tac-toe game-state owner: board register, move handshake, legality
// checks, turn alternation and turn-timeout auto-play.
module board_controller
  import tictactoe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_cell,
  output logic        move_ready,
  input  logic        victory,
  output logic [17:0] matrix,
  output logic        turn,
  output logic [3:0]  move_count,
  output logic        move_error,
  output logic        timeout,
  output logic        game_over,
  output logic        last_player
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  ctrl_state_t   state, state_nxt;
  logic [TW-1:0] timer;
  logic [3:0]    auto_idx, place_idx;
  logic          auto_found;
  logic          accept, cell_ok, legal, illegal, expire, place;

  empty_cell_finder u_finder (
    .board (matrix),
    .idx   (auto_idx),
    .found (auto_found)
  );

  assign cell_ok   = (cell_of(matrix, move_cell) == CELL_EMPTY);
  assign accept    = move_valid & move_ready;
  assign legal     = accept & cell_ok;
  assign illegal   = accept & ~cell_ok;
  // An illegal request in the expiry cycle still lets the auto-move run.
  assign expire    = TO_EN && (state == TURN) && (timer == TLAST) && !legal && auto_found;
  assign place     = legal | expire;
  assign place_idx = legal ? move_cell : auto_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_game) state_nxt = TURN;
    else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        TURN:    if (place) state_nxt = CHECK;
        CHECK:   state_nxt = victory ? OVER : TURN;
        OVER:    state_nxt = OVER;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    move_ready = (state == TURN);
    game_over  = (state == OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      matrix      <= '0;
      turn        <= 1'b0;
      move_count  <= '0;
      last_player <= 1'b0;
      timer       <= '0;
      move_error  <= 1'b0;
      timeout     <= 1'b0;
    end else if (new_game) begin
      matrix      <= '0;
      turn        <= 1'b0;
      move_count  <= '0;
      timer       <= '0;
      move_error  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      move_error <= illegal;
      timeout    <= expire;
      if (place) begin
        for (int i = 0; i < N_CELLS; i++)
          if (place_idx == 4'(i)) matrix[2*i +: 2] <= player_code(turn);
        move_count  <= move_count + 4'd1;
        last_player <= turn;
      end
      // Timer holds on a rejected request and idles while a move is pending check.
      if (state == CHECK && !victory) begin
        turn  <= ~turn;
        timer <= '0;
      end else if (TO_EN && state == TURN && !move_valid) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_controller.sv
// Randomized plus directed bench for board_controller against an array-based game model.
module tb_board_controller;

  localparam int TO = 5;
  localparam int PH_IDLE = 0, PH_TURN = 1, PH_CHECK = 2, PH_OVER = 3;

  logic        clk = 1'b0;
  logic        rst_n, new_game, move_valid, victory;
  logic [3:0]  move_cell;
  logic        move_ready, turn, move_error, timeout, game_over, last_player;
  logic [17:0] matrix;
  logic [3:0]  move_count;

  int n_cmp = 0;
  int n_bad = 0;

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  // reference game model
  int mb [9];
  int mph, mturn, mcount, mlast, mtimer, merr, mto;

  always #5 clk = ~clk;

  board_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .new_game    (new_game),
    .move_valid  (move_valid),
    .move_cell   (move_cell),
    .move_ready  (move_ready),
    .victory     (victory),
    .matrix      (matrix),
    .turn        (turn),
    .move_count  (move_count),
    .move_error  (move_error),
    .timeout     (timeout),
    .game_over   (game_over),
    .last_player (last_player)
  );

  function automatic bit wins(input int b[9]);
    int filled;
    for (int l = 0; l < 8; l++)
      if (b[lines[l][0]] != 0 && b[lines[l][0]] == b[lines[l][1]] &&
          b[lines[l][0]] == b[lines[l][2]]) return 1'b1;
    filled = 0;
    for (int i = 0; i < 9; i++) if (b[i] != 0) filled++;
    return filled == 9;
  endfunction

  function automatic bit win_vec(input logic [17:0] m);
    int b[9];
    for (int i = 0; i < 9; i++) b[i] = int'(m[2*i +: 2]);
    return wins(b);
  endfunction

  // upstream victory detector stand-in
  assign victory = win_vec(matrix);

  function automatic logic [17:0] pack_model();
    logic [17:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) m[2*i +: 2] = 2'(mb[i]);
    return m;
  endfunction

  task automatic model_place(input int c);
    mb[c]  = (mturn != 0) ? 2 : 1;
    mcount = mcount + 1;
    mlast  = mturn;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mturn = 0; mcount = 0; mtimer = 0; merr = 0; mto = 0;
  endtask

  task automatic model_step();
    bit legal;
    int c, e;
    legal = 1'b0;
    c = int'(move_cell);
    if (!rst_n) begin
      model_clear();
      mlast = 0;
      mph   = PH_IDLE;
    end else if (new_game) begin
      model_clear();
      mph = PH_TURN;
    end else begin
      merr = 0;
      mto  = 0;
      if (mph == PH_TURN) begin
        if (move_valid) begin
          if (c < 9 && mb[c] == 0) legal = 1'b1;
          else merr = 1;
        end
        if (legal) begin
          model_place(c);
          mph = PH_CHECK;
        end else if (mtimer == TO - 1) begin
          e = 0;
          while (mb[e] != 0) e++;
          model_place(e);
          mto = 1;
          mph = PH_CHECK;
        end else if (!move_valid) begin
          mtimer++;
        end
      end else if (mph == PH_CHECK) begin
        if (wins(mb)) mph = PH_OVER;
        else begin
          mturn  = 1 - mturn;
          mtimer = 0;
          mph    = PH_TURN;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("matrix",      32'(matrix),      32'(pack_model()));
    chk("move_ready",  32'(move_ready),  32'(mph == PH_TURN));
    chk("game_over",   32'(game_over),   32'(mph == PH_OVER));
    chk("turn",        32'(turn),        32'(mturn));
    chk("move_count",  32'(move_count),  32'(mcount));
    chk("last_player", 32'(last_player), 32'(mlast));
    chk("move_error",  32'(move_error),  32'(merr));
    chk("timeout",     32'(timeout),     32'(mto));
  endtask

  task automatic cyc(input logic rn, input logic ng, input logic mv, input logic [3:0] mc);
    rst_n      = rn;
    new_game   = ng;
    move_valid = mv;
    move_cell  = mc;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();               cyc(1'b1, 1'b0, 1'b0, 4'd0); endtask
  task automatic play(input logic [3:0] c); cyc(1'b1, 1'b0, 1'b1, c); endtask
  task automatic ng();                 cyc(1'b1, 1'b1, 1'b0, 4'd0); endtask

  initial begin
    logic rn, g, mv;
    logic [3:0] mc;
    int rate;
    rst_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_cell = '0;
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mph = PH_IDLE; mturn = 0; mcount = 0; mlast = 0; mtimer = 0; merr = 0; mto = 0;

    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    chk("rst_matrix", 32'(matrix), 32'h0);
    chk("rst_ready",  32'(move_ready), 32'h0);
    chk("rst_over",   32'(game_over), 32'h0);
    chk("rst_count",  32'(move_count), 32'h0);

    ng();
    chk("ng_ready", 32'(move_ready), 32'h1);
    play(4'd4);
    chk("p1_c4_matrix", 32'(matrix), 32'h00100);
    chk("p1_c4_count",  32'(move_count), 32'h1);
    chk("p1_c4_ready",  32'(move_ready), 32'h0);
    idle();
    chk("p1_c4_turn", 32'(turn), 32'h1);
    play(4'd4);
    chk("occ_err",    32'(move_error), 32'h1);
    chk("occ_matrix", 32'(matrix), 32'h00100);
    play(4'd9);
    chk("c9_err",  32'(move_error), 32'h1);
    chk("c9_turn", 32'(turn), 32'h1);
    idle();
    chk("err_pulse_end", 32'(move_error), 32'h0);

    ng();
    play(4'd0); idle(); play(4'd3); idle(); play(4'd1); idle(); play(4'd4); idle();
    play(4'd2);
    chk("win_in_check", 32'(game_over), 32'h0);
    idle();
    chk("win_over",   32'(game_over), 32'h1);
    chk("win_last",   32'(last_player), 32'h0);
    chk("win_matrix", 32'(matrix), 32'h00295);
    play(4'd5);
    chk("over_frozen", 32'(matrix), 32'h00295);
    chk("over_noerr",  32'(move_error), 32'h0);

    ng();
    repeat (5) idle();
    chk("to_pulse",  32'(timeout), 32'h1);
    chk("to_matrix", 32'(matrix), 32'h00001);
    idle();
    chk("to_pulse_end", 32'(timeout), 32'h0);

    ng();
    repeat (4) idle();
    play(4'd7);
    chk("legal_beats_to", 32'(timeout), 32'h0);
    chk("legal_cell7",    32'(matrix), 32'h04000);

    ng();
    play(4'd2);
    ng();
    chk("ng_check_matrix", 32'(matrix), 32'h0);
    chk("ng_check_turn",   32'(turn), 32'h0);
    chk("ng_check_ready",  32'(move_ready), 32'h1);

    play(4'd6);
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    chk("rst_ng_matrix", 32'(matrix), 32'h0);
    chk("rst_ng_ready",  32'(move_ready), 32'h0);
    chk("rst_ng_count",  32'(move_count), 32'h0);

    for (int k = 0; k < 3000; k++) begin
      rate = ((k / 300) % 2 == 0) ? 60 : 12;
      rn = ($urandom_range(0, 299) != 0);
      g  = ($urandom_range(0, 39) == 0);
      mv = ($urandom_range(0, 99) < rate);
      mc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      cyc(rn, g, mv, mc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_controller.md
# board_controller

Sequential game-state owner for the tic-tac-toe datapath, directly upstream of the victory detector. It holds the 3×3 board register, accepts moves over a valid/ready handshake, rejects illegal moves, alternates turns and auto-plays on turn timeout. It drives the 18-bit board to the detector and consumes the detector's combinational `victory` flag to end the game.

## Interface
- `TIMEOUT_CYCLES`, default 0, cycles allowed per turn before an auto-move; 0 disables the timeout.
- `clk  in  1` — single clock; all state changes on the rising edge.
- `rst_n  in  1` — synchronous, active-low reset.
- `new_game  in  1` — single-cycle pulse; clears the board and starts a game with player 1 to move.
- `move_valid  in  1` — move request.
- `move_cell  in  4` — target cell, 0..8.
- `move_ready  out  1` — controller can accept a move this cycle.
- `victory  in  1` — from the victory detector; win by either player or full board.
- `matrix  out  18` — board to the detector; cell i occupies bits [2i+1:2i].
- `turn  out  1` — player to move: 0 = P1, 1 = P2.
- `move_count  out  4` — occupied cells, 0..9.
- `move_error  out  1` — one-cycle pulse on a rejected move.
- `timeout  out  1` — one-cycle pulse on an auto-move.
- `game_over  out  1` — high while in OVER.
- `last_player  out  1` — player who made the most recent placement.

## Operation
- Cell codes:
  - 2'b00 empty.
  - 2'b01 P1.
  - 2'b10 P2.
  - 2'b11 never written.
- Reset values: `matrix` 0, state IDLE, `turn` 0, `move_count` 0, `last_player` 0, timer 0; `move_ready`, `move_error`, `timeout` and `game_over` all 0.
- FSM states: IDLE, TURN, CHECK, OVER.
  - IDLE: waits for `new_game`.
  - TURN: `move_ready`=1; timer counts.
  - CHECK: one cycle; `victory` is evaluated against the updated `matrix`.
  - OVER: `game_over`=1; board frozen; moves ignored with no error pulse.
- Transitions:
  - IDLE --`new_game`--> TURN.
  - TURN --accepted legal move or auto-move--> CHECK.
  - CHECK --`victory`--> OVER.
  - CHECK --!`victory`--> TURN, with `turn` toggled and timer cleared.
  - Any state --`new_game`--> TURN, with board, `move_count` and timer cleared and `turn`=0.
- A move is accepted when `move_valid` & `move_ready`. It is legal when `move_cell` ≤ 8 and that cell is empty.
  - Legal move: write the current player's code, increment `move_count`, set `last_player`=`turn`.
  - Illegal move: `move_error` pulses in the next cycle; board, state and timer are unchanged.
- Timeout (TIMEOUT_CYCLES>0): the timer increments each TURN cycle with no legal move. When it reaches TIMEOUT_CYCLES-1 and there is no legal move that cycle, the controller places the current player's code in the lowest-indexed empty cell and pulses `timeout` in the next cycle.
- TURN always has at least one empty cell, because a full board makes `victory` high in CHECK.
- Simultaneous events, in priority order:
  1. `new_game` overrides everything, including reset-free mid-game states.
  2. A legal move beats a timeout in the same cycle.
  3. An illegal move in the timeout cycle pulses both `move_error` and `timeout`; the auto-move executes.
- A draw is not distinguished from a win. Downstream reads `last_player` and decides.

## Timing
- Move accepted at edge N: `matrix`, `move_count` and `last_player` update at N; state is CHECK during cycle N+1.
- At edge N+1: OVER if `victory`, else TURN with the new `turn`.
- Move-to-move throughput is 2 cycles minimum; `move_ready` is low during CHECK.
- `move_error` and `timeout` are registered pulses, high for exactly the cycle after the triggering edge.
- `new_game` takes effect at the next edge; `move_ready` is high in the following cycle.
- `rst_n` low at any edge forces reset values and overrides `new_game`.

## Structure
- Shared package `tictactoe_pkg` holds:
  - Cell-code constants: CELL_EMPTY, CELL_P1, CELL_P2.
  - N_CELLS = 9.
  - State enum `ctrl_state_t`.
  - The cell-slice helper function.
  - The victory detector uses the same cell codes.
- Sub-module `empty_cell_finder`: combinational priority encoder, 18-bit board in, 4-bit lowest empty index plus `found` flag out.
- Timer width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- The victory detector is instantiated by the parent; this block only consumes `victory`.

## Test plan
- Reset, then `new_game`, then P1 plays cell 4: `matrix`=18'h00100 and `turn`=1 after CHECK; `move_count`=1.
- P2 plays occupied cell 4, then cell 9: each gives one `move_error` pulse; `matrix` unchanged; `turn` stays 1.
- P1 plays 0, P2 plays 3, P1 plays 1, P2 plays 4, P1 plays 2: `victory` is high in CHECK, `game_over`=1, `last_player`=0; a further move is ignored.
- TIMEOUT_CYCLES=5 with P1 on an empty board and no move for 5 cycles: `timeout` pulses and cell 0 becomes 2'b01. A legal move on cycle 5 wins over the timeout.
- `new_game` asserted during CHECK: next cycle `matrix`=0, `turn`=0, state TURN.
- `new_game` and `rst_n`=0 asserted together: all outputs take reset values and state is IDLE.
